// File: rtl/reg_arb_pkg.sv
// Shared constants for the two-writer register arbiter: state encoding,
// grant identifiers and the default data width.
package reg_arb_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_WRITE = 2'd1;
  localparam logic [ST_W-1:0] ST_CHECK = 2'd2;
  localparam logic [ST_W-1:0] ST_ACK   = 2'd3;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
  import reg_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req_a | req_b;
    winner = GNT_A;
    if (req_a && req_b) begin
      winner = ~last_grant;
    end else if (req_b) begin
      winner = GNT_B;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one enable register between writers A and B: grants round-robin,
// pulses the register enable once, reads the value back and acks the winner.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_ext,
  input  logic             req_a,
  input  logic [WIDTH-1:0] d_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] d_b,
  output logic             ack_b,
  output logic             wr_err,
  output logic             reg_en,
  output logic [WIDTH-1:0] reg_d,
  input  logic [WIDTH-1:0] reg_q,
  output logic             busy
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_en_q, reg_en_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             mism_q, mism_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             wr_err_q, wr_err_d;
  logic             busy_q, busy_d;

  logic             pick_valid;
  logic             pick_winner;

  rr_pick2 u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state and registered-output logic; ack/err are loaded in CHECK so
  // they appear exactly during the ACK cycle.
  always_comb begin
    state_d  = state_q;
    reg_d_d  = reg_d_q;
    reg_en_d = 1'b0;
    gnt_d    = gnt_q;
    last_d   = last_q;
    mism_d   = mism_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    wr_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_WRITE;
          reg_en_d = 1'b1;
          gnt_d    = pick_winner;
          reg_d_d  = (pick_winner == GNT_B) ? d_b : d_a;
        end
      end
      ST_WRITE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        mism_d   = (reg_q != reg_d_q);
        state_d  = ST_ACK;
        ack_a_d  = (gnt_q == GNT_A);
        ack_b_d  = (gnt_q == GNT_B);
        wr_err_d = mism_d;
      end
      ST_ACK: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      state_q  <= ST_IDLE;
      reg_d_q  <= '0;
      reg_en_q <= 1'b0;
      gnt_q    <= GNT_A;
      last_q   <= GNT_B;
      mism_q   <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      wr_err_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_d_q  <= reg_d_d;
      reg_en_q <= reg_en_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      mism_q   <= mism_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      wr_err_q <= wr_err_d;
      busy_q   <= busy_d;
    end
  end

  assign ack_a  = ack_a_q;
  assign ack_b  = ack_b_q;
  assign wr_err = wr_err_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign busy   = busy_q;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Sequencer that shares the 4-bit enable register between two independent writers (A and B).
- Arbitrates their requests round-robin and drives the register's enable/data inputs for exactly one cycle per granted write.
- Reads the register output back to confirm the write, then acknowledges the winning requester with a pass/fail status.
- Sits between the requester logic and the register instance in `top`; the register is the only consumer of `reg_en`/`reg_d`.

## Interface
- `WIDTH`, default 4: data width of the shared register.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_ext`  in  1  synchronous, active-high reset; shared with the register.
- `req_a`  in  1  requester A write request; level, held until `ack_a`.
- `d_a`  in  WIDTH  requester A write data; stable while `req_a` is high.
- `ack_a`  out  1  one-cycle completion pulse to A.
- `req_b`  in  1  requester B write request; level, held until `ack_b`.
- `d_b`  in  WIDTH  requester B write data.
- `ack_b`  out  1  one-cycle completion pulse to B.
- `wr_err`  out  1  readback mismatch; valid only in the cycle `ack_a` or `ack_b` is high, 0 otherwise.
- `reg_en`  out  1  to register enable; high for exactly one cycle per write.
- `reg_d`  out  WIDTH  to register data; holds the last granted data.
- `reg_q`  in  WIDTH  register output, used for readback.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WRITE, CHECK, ACK.
  - IDLE: if any request is high, pick a winner, latch its data into `reg_d`, record the grant, assert `reg_en`, and go to WRITE. With no requests, stay in IDLE.
  - WRITE: `reg_en` is high; the register captures `reg_d` on the edge that ends this cycle. Deassert `reg_en` and go to CHECK.
  - CHECK: compare `reg_q` with `reg_d`, register the result into the mismatch flag, and go to ACK.
  - ACK: pulse the granted requester's ack, drive `wr_err` from the mismatch flag, update `last_grant`, and go to IDLE.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not equal to `last_grant` wins.
  - `last_grant` resets to B, so A wins the first tie.
- Handshake:
  - A requester must drop `req` in its ack cycle or by the following IDLE cycle. A request still high in IDLE is treated as a new write.
  - Dropping `req` after a grant does not abort the write; the ack still pulses.
  - A non-granted request stays pending and is served next. No starvation: with both held high, grants alternate A, B, A, B.
- Requests are sampled only in IDLE; input changes in other states are ignored.
- Reset values: state IDLE; `reg_en` 0; `reg_d` 0; `ack_a`/`ack_b` 0; `wr_err` 0; `busy` 0; mismatch flag 0; `last_grant` B.
- Reset in mid-transaction returns to IDLE with no ack and no error reported. The register is also cleared by the same reset.

## Timing
- Request sampled high in IDLE at cycle N:
  - `reg_en`=1 and `reg_d`=data during N+1.
  - Register `q` holds the new value from N+2.
  - Ack pulse during N+3.
  - IDLE again at N+4.
- Throughput: one write per 4 cycles. Back-to-back grants are 4 cycles apart.
- All outputs are registered; no combinational path from any input to any output.
- `busy` is high during N+1..N+3.

## Structure
- Shared package `reg_arb_pkg`:
  - State encoding localparams (IDLE=2'd0, WRITE=2'd1, CHECK=2'd2, ACK=2'd3).
  - Grant-id constants (GNT_A=1'b0, GNT_B=1'b1).
  - Default `WIDTH`=4.
- One sub-module, `rr_pick2`: purely combinational two-way round-robin selector (inputs `req_a`, `req_b`, `last_grant`; outputs `valid`, `winner`).
- The FSM, data latch and readback compare stay in `reg_write_arbiter`. The top-level bench instantiates the arbiter together with the existing register.

## Test plan
- Reset with `rst_ext`=1 for 2 cycles, then release with no requests -> all outputs 0, `busy`=0, register `q`=0000.
- `req_a`=1, `d_a`=1010 at N -> `reg_en`=1 only in N+1; `q`=1010 at N+2; `ack_a`=1 with `wr_err`=0 in N+3; `ack_b` stays 0.
- `req_a`=`req_b`=1 held high, `d_a`=0101, `d_b`=1111 -> grants A then B four cycles apart; `q` sequence 0101 then 1111; acks alternate, repeating A, B.
- `req_b`=1, `d_b`=0011 alone after a previous grant to B -> B wins again (no idle-priority penalty); `ack_b` at N+3.
- `rst_ext`=1 during CHECK of a write of 1100 -> next cycle state IDLE, no ack, `wr_err`=0, `q`=0000.
- Bench forces `reg_q` to 0000 after a write of 1001 -> `ack_a`=1 with `wr_err`=1 in the same cycle, `wr_err`=0 afterwards.
